init_reset_sequencer: RTL and testbench

INIT_RESET_SEQUENCER -- requirements
Module: init_reset_sequencer

---
 rtl/init_reset_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_init_reset_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/init_reset_sequencer.sv
// ----------------------------------------------------------------------------
// init_reset_sequencer
//
// Purpose:
//   Power-up / re-lock reset sequencer for the fabric. It waits for device init
//   complete, qualifies the PLL lock with a consecutive-cycle filter and holds
//   the fabric in reset for a fixed number of cycles. Only then does it release
//   FABRIC_RESET_N. Losing init, lock or the external reset request sends the
//   sequence back to the start.
//
// Parameters:
//   SYNC_STAGES        synchronizer depth for each asynchronous input (>= 2)
//   LOCK_FILTER_CYCLES consecutive synchronized lock-high cycles (1..255)
//   HOLD_CYCLES        cycles FABRIC_RESET_N stays low after lock (1..65535)
//   WDOG_CYCLES        WAIT_LOCK timeout, used only with the watchdog build
//
// Ports:
//   CLK            in   single clock, all flops on its rising edge
//   RESETN         in   asynchronous active-low reset (device FABRIC_POR_N)
//   INIT_DONE      in   device init complete, asynchronous to CLK
//   PLL_LOCK       in   fabric PLL lock, asynchronous to CLK
//   EXT_RST_N      in   external reset request, active-low, asynchronous
//   FABRIC_RESET_N out  registered active-low fabric reset
//   STATE          out  FSM state (00 WAIT_INIT, 01 WAIT_LOCK, 10 HOLD, 11 RUN)
//   LOCK_LOST      out  sticky: lock dropped while in RUN
//   LOCK_TIMEOUT   out  sticky: watchdog expired in WAIT_LOCK
//
// Build option:
//   INIT_RESET_SEQ_WATCHDOG_EN  define to include the WAIT_LOCK watchdog. When
//                               it is undefined, LOCK_TIMEOUT is tied to 0.
// ----------------------------------------------------------------------------
module init_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_FILTER_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES        = 16,
  parameter int unsigned WDOG_CYCLES        = 1024
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       INIT_DONE,
  input  logic       PLL_LOCK,
  input  logic       EXT_RST_N,
  output logic       FABRIC_RESET_N,
  output logic [1:0] STATE,
  output logic       LOCK_LOST,
  output logic       LOCK_TIMEOUT
);

  typedef enum logic [1:0] {
    WAIT_INIT = 2'b00,
    WAIT_LOCK = 2'b01,
    HOLD      = 2'b10,
    RUN       = 2'b11
  } state_e;

  localparam logic [7:0]  FILT_LAST = 8'(LOCK_FILTER_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  // An out-of-range parameter would silently truncate a counter. Instead of
  // running with a wrong count, such a build keeps the fabric in reset.
  localparam bit PARAMS_OK = (SYNC_STAGES >= 2) &&
                             (LOCK_FILTER_CYCLES >= 1) && (LOCK_FILTER_CYCLES <= 255) &&
                             (HOLD_CYCLES >= 1) && (HOLD_CYCLES <= 65535) &&
                             (WDOG_CYCLES >= 1) && (WDOG_CYCLES <= 65536);

  // --------------------------------------------------------------------------
  // Input synchronizers and reset-release synchronizer
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] init_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic [1:0]             rel_sync_q;

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the values from before the edge, which is what makes a shift
  // register behave as one.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      init_sync_q <= '0;
      lock_sync_q <= '0;
      ext_sync_q  <= '0;
      rel_sync_q  <= '0;
    end else begin
      init_sync_q <= {init_sync_q[SYNC_STAGES-2:0], INIT_DONE};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], PLL_LOCK};
      ext_sync_q  <= {ext_sync_q[SYNC_STAGES-2:0], EXT_RST_N};
      rel_sync_q  <= {rel_sync_q[0], 1'b1};
    end
  end

  logic init_s, lock_s, ext_s, rel_ok;
  assign init_s = init_sync_q[SYNC_STAGES-1];
  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign ext_s  = ext_sync_q[SYNC_STAGES-1];
  assign rel_ok = rel_sync_q[1] && PARAMS_OK;

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [7:0]  filt_cnt_q, filt_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        fabric_rst_n_q;
  logic        lock_lost_q, lock_lost_d;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    filt_cnt_d  = filt_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    lock_lost_d = lock_lost_q | ((state_q == RUN) && !lock_s);

    unique case (state_q)
      WAIT_INIT: begin
        filt_cnt_d = '0;
        hold_cnt_d = '0;
        if (rel_ok && init_s && ext_s) state_d = WAIT_LOCK;
      end

      WAIT_LOCK: begin
        // Missing lock here only restarts the filter. Aborting on it would
        // bounce WAIT_LOCK <-> WAIT_INIT while the PLL settles, and then the
        // watchdog could never accumulate time in WAIT_LOCK.
        if (!init_s || !ext_s) begin
          state_d    = WAIT_INIT;
          filt_cnt_d = '0;
        end else if (!lock_s) begin
          filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_LAST) begin
          state_d    = HOLD;
          filt_cnt_d = '0;
          hold_cnt_d = '0;
        end else begin
          filt_cnt_d = filt_cnt_q + 8'd1;
        end
      end

      HOLD: begin
        // The abort is checked first, so it wins even on the final hold count.
        if (!init_s || !lock_s || !ext_s) begin
          state_d    = WAIT_INIT;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end

      RUN: begin
        if (!init_s || !lock_s || !ext_s) state_d = WAIT_INIT;
      end

      default: state_d = WAIT_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q        <= WAIT_INIT;
      filt_cnt_q     <= '0;
      hold_cnt_q     <= '0;
      fabric_rst_n_q <= 1'b0;
      lock_lost_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      filt_cnt_q     <= filt_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      // Decoding the next state keeps the release glitch-free and in step with
      // the state register.
      fabric_rst_n_q <= (state_d == RUN);
      lock_lost_q    <= lock_lost_d;
    end
  end

  assign FABRIC_RESET_N = fabric_rst_n_q;
  assign STATE          = state_q;
  assign LOCK_LOST      = lock_lost_q;

  // --------------------------------------------------------------------------
  // Optional WAIT_LOCK watchdog: flags a PLL that never locks. It does not
  // change the sequence.
  // --------------------------------------------------------------------------
`ifdef INIT_RESET_SEQ_WATCHDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    wdog_cnt_d = '0;
    timeout_d  = timeout_q;
    if (state_q == WAIT_LOCK) begin
      if (wdog_cnt_q == WDOG_LAST) begin
        wdog_cnt_d = wdog_cnt_q;
        timeout_d  = 1'b1;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wdog_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign LOCK_TIMEOUT = timeout_q;
`else
  assign LOCK_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_init_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_init_reset_sequencer
//
// Directed testbench for init_reset_sequencer at default parameters. Inputs
// change just after a falling edge and outputs are sampled on falling edges.
// As a result, "edge k" is the rising edge that follows the stimulus change.
// ----------------------------------------------------------------------------
module tb_init_reset_sequencer;

  logic       CLK;
  logic       RESETN;
  logic       INIT_DONE;
  logic       PLL_LOCK;
  logic       EXT_RST_N;
  logic       FABRIC_RESET_N;
  logic [1:0] STATE;
  logic       LOCK_LOST;
  logic       LOCK_TIMEOUT;

  int n_checks;
  int n_fail;

  init_reset_sequencer dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .INIT_DONE      (INIT_DONE),
    .PLL_LOCK       (PLL_LOCK),
    .EXT_RST_N      (EXT_RST_N),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .STATE          (STATE),
    .LOCK_LOST      (LOCK_LOST),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("FAIL sim_timeout: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1, "simulation time limit reached");
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Reset, then release with INIT_DONE/EXT_RST_N high and PLL_LOCK low.
  // Release edges e1,e2 fill the synchronizers. Edge e3 enters WAIT_LOCK.
  task automatic do_reset();
    RESETN    = 1'b0;
    INIT_DONE = 1'b1;
    EXT_RST_N = 1'b1;
    PLL_LOCK  = 1'b0;
    step(2);
    RESETN = 1'b1;
    step(3);
  endtask

  task automatic test_reset();
    RESETN    = 1'b0;
    INIT_DONE = 1'b0;
    EXT_RST_N = 1'b1;
    PLL_LOCK  = 1'b0;
    step(2);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fabric: got %b expected 0", FABRIC_RESET_N);
    end
    n_checks++;
    if (STATE !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 00", STATE);
    end
    n_checks++;
    if (LOCK_LOST !== 1'b0 || LOCK_TIMEOUT !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got lost=%b timeout=%b expected 0/0", LOCK_LOST, LOCK_TIMEOUT);
    end
    RESETN = 1'b1;
    step(6);
    n_checks++;
    if (STATE !== 2'b00) begin
      n_fail++;
      $display("FAIL wait_init_hold: got %b expected 00", STATE);
    end
    // INIT_DONE rises before edge m. It is synchronized after m+1, and edge
    // m+2 moves the FSM to WAIT_LOCK.
    INIT_DONE = 1'b1;
    step(2);
    n_checks++;
    if (STATE !== 2'b00) begin
      n_fail++;
      $display("FAIL init_sync_latency: got %b expected 00", STATE);
    end
    step(1);
    n_checks++;
    if (STATE !== 2'b01) begin
      n_fail++;
      $display("FAIL enter_wait_lock: got %b expected 01", STATE);
    end
  endtask

  // PLL_LOCK rises before edge k. HOLD follows edge k+9 and RUN follows k+25.
  task automatic test_nominal();
    do_reset();
    PLL_LOCK = 1'b1;
    step(10);
    n_checks++;
    if (STATE !== 2'b10) begin
      n_fail++;
      $display("FAIL nominal_enter_hold: got %b expected 10", STATE);
    end
    step(15);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b0 || STATE !== 2'b10) begin
      n_fail++;
      $display("FAIL nominal_before_run: got fabric=%b state=%b expected 0/10", FABRIC_RESET_N, STATE);
    end
    step(1);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b1 || STATE !== 2'b11) begin
      n_fail++;
      $display("FAIL nominal_run: got fabric=%b state=%b expected 1/11", FABRIC_RESET_N, STATE);
    end
  endtask

  // 5 high, 1 low, then high again before edge k'. Release follows k'+25.
  task automatic test_lock_glitch();
    do_reset();
    PLL_LOCK = 1'b1;
    step(5);
    PLL_LOCK = 1'b0;
    step(1);
    PLL_LOCK = 1'b1;
    step(9);
    n_checks++;
    if (STATE !== 2'b01) begin
      n_fail++;
      $display("FAIL glitch_filter_restart: got %b expected 01", STATE);
    end
    step(16);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_before_run: got %b expected 0", FABRIC_RESET_N);
    end
    step(1);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b1 || STATE !== 2'b11) begin
      n_fail++;
      $display("FAIL glitch_run: got fabric=%b state=%b expected 1/11", FABRIC_RESET_N, STATE);
    end
  endtask

  // Starts in RUN. Lock drops before edge j, and edge j+2 aborts.
  task automatic test_lock_loss();
    n_checks++;
    if (LOCK_LOST !== 1'b0) begin
      n_fail++;
      $display("FAIL lost_before_drop: got %b expected 0", LOCK_LOST);
    end
    PLL_LOCK = 1'b0;
    step(2);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b1 || STATE !== 2'b11) begin
      n_fail++;
      $display("FAIL lost_sync_delay: got fabric=%b state=%b expected 1/11", FABRIC_RESET_N, STATE);
    end
    step(1);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b0 || STATE !== 2'b00 || LOCK_LOST !== 1'b1) begin
      n_fail++;
      $display("FAIL lost_abort: got fabric=%b state=%b lost=%b expected 0/00/1",
               FABRIC_RESET_N, STATE, LOCK_LOST);
    end
    // Lock returns before edge k=j+3, while the FSM re-enters WAIT_LOCK.
    PLL_LOCK = 1'b1;
    step(1);
    n_checks++;
    if (STATE !== 2'b01) begin
      n_fail++;
      $display("FAIL lost_reenter_wait_lock: got %b expected 01", STATE);
    end
    step(24);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b0) begin
      n_fail++;
      $display("FAIL lost_resequence_early: got %b expected 0", FABRIC_RESET_N);
    end
    step(1);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b1 || LOCK_LOST !== 1'b1) begin
      n_fail++;
      $display("FAIL lost_resequence_run: got fabric=%b lost=%b expected 1/1", FABRIC_RESET_N, LOCK_LOST);
    end
  endtask

  // EXT_RST_N low for one cycle before edge j while in RUN. Edge j+2 aborts,
  // j+3 enters WAIT_LOCK, j+11 enters HOLD and j+27 enters RUN.
  task automatic test_ext_reset();
    do_reset();
    PLL_LOCK = 1'b1;
    step(26);
    EXT_RST_N = 1'b0;
    step(1);
    EXT_RST_N = 1'b1;
    step(1);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b1) begin
      n_fail++;
      $display("FAIL ext_sync_delay: got %b expected 1", FABRIC_RESET_N);
    end
    step(1);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b0 || STATE !== 2'b00) begin
      n_fail++;
      $display("FAIL ext_abort: got fabric=%b state=%b expected 0/00", FABRIC_RESET_N, STATE);
    end
    step(1);
    n_checks++;
    if (STATE !== 2'b01) begin
      n_fail++;
      $display("FAIL ext_wait_lock: got %b expected 01", STATE);
    end
    step(8);
    n_checks++;
    if (STATE !== 2'b10) begin
      n_fail++;
      $display("FAIL ext_hold: got %b expected 10", STATE);
    end
    step(15);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_before_run: got %b expected 0", FABRIC_RESET_N);
    end
    step(1);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b1 || LOCK_LOST !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_run: got fabric=%b lost=%b expected 1/0", FABRIC_RESET_N, LOCK_LOST);
    end
  endtask

  // RESETN pulsed while the hold counter reads 7. After release, the lock is
  // already high: e3 enters WAIT_LOCK, e11 enters HOLD and e27 enters RUN.
  task automatic test_mid_hold_reset();
    do_reset();
    PLL_LOCK = 1'b1;
    step(17);
    n_checks++;
    if (STATE !== 2'b10) begin
      n_fail++;
      $display("FAIL midhold_in_hold: got %b expected 10", STATE);
    end
    #2;
    RESETN = 1'b0;
    #1;
    n_checks++;
    if (FABRIC_RESET_N !== 1'b0 || STATE !== 2'b00 || LOCK_LOST !== 1'b0 || LOCK_TIMEOUT !== 1'b0) begin
      n_fail++;
      $display("FAIL midhold_async_reset: got fabric=%b state=%b lost=%b timeout=%b expected 0/00/0/0",
               FABRIC_RESET_N, STATE, LOCK_LOST, LOCK_TIMEOUT);
    end
    @(negedge CLK);
    RESETN = 1'b1;
    step(3);
    n_checks++;
    if (STATE !== 2'b01) begin
      n_fail++;
      $display("FAIL midhold_release_wait_lock: got %b expected 01", STATE);
    end
    step(8);
    n_checks++;
    if (STATE !== 2'b10) begin
      n_fail++;
      $display("FAIL midhold_rehold: got %b expected 10", STATE);
    end
    step(15);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b0) begin
      n_fail++;
      $display("FAIL midhold_before_run: got %b expected 0", FABRIC_RESET_N);
    end
    step(1);
    n_checks++;
    if (FABRIC_RESET_N !== 1'b1) begin
      n_fail++;
      $display("FAIL midhold_run: got %b expected 1", FABRIC_RESET_N);
    end
  endtask

  // Starts in RUN: async reset drops the fabric reset at once. Then PLL_LOCK
  // is held low. WAIT_LOCK is entered at e3, and its 1024th edge is e1027.
  task automatic test_watchdog();
    #2;
    RESETN = 1'b0;
    #1;
    n_checks++;
    if (FABRIC_RESET_N !== 1'b0 || STATE !== 2'b00) begin
      n_fail++;
      $display("FAIL run_async_reset: got fabric=%b state=%b expected 0/00", FABRIC_RESET_N, STATE);
    end
    @(negedge CLK);
    PLL_LOCK  = 1'b0;
    INIT_DONE = 1'b1;
    EXT_RST_N = 1'b1;
    RESETN    = 1'b1;
    step(3);
    n_checks++;
    if (STATE !== 2'b01) begin
      n_fail++;
      $display("FAIL wdog_wait_lock: got %b expected 01", STATE);
    end
`ifdef INIT_RESET_SEQ_WATCHDOG_EN
    step(1023);
    n_checks++;
    if (LOCK_TIMEOUT !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_early: got %b expected 0", LOCK_TIMEOUT);
    end
    step(1);
    n_checks++;
    if (LOCK_TIMEOUT !== 1'b1 || STATE !== 2'b01) begin
      n_fail++;
      $display("FAIL wdog_fire: got timeout=%b state=%b expected 1/01", LOCK_TIMEOUT, STATE);
    end
    step(10);
    n_checks++;
    if (LOCK_TIMEOUT !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_sticky: got %b expected 1", LOCK_TIMEOUT);
    end
`else
    step(1100);
    n_checks++;
    if (LOCK_TIMEOUT !== 1'b0 || STATE !== 2'b01) begin
      n_fail++;
      $display("FAIL wdog_absent: got timeout=%b state=%b expected 0/01", LOCK_TIMEOUT, STATE);
    end
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RESETN    = 1'b0;
    INIT_DONE = 1'b0;
    PLL_LOCK  = 1'b0;
    EXT_RST_N = 1'b1;

    test_reset();
    test_nominal();
    test_lock_glitch();
    test_lock_loss();
    test_ext_reset();
    test_mid_hold_reset();
    test_watchdog();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
